// File: rtl/video_sync_v.sv
// Vertical line counter, blank/sync/pixel-window decode and Z80 INT pulse generator.
// Optional early INT release via int_ack_i when SYNCV_INT_ACK_EN is defined.
module video_sync_v #(
  parameter logic [8:0] VPERIOD   = 9'd320,
  parameter logic [8:0] VBLNK_BEG = 9'd0,
  parameter logic [8:0] VSYNC_BEG = 9'd8,
  parameter logic [8:0] VSYNC_END = 9'd12,
  parameter logic [8:0] VBLNK_END = 9'd32,
  parameter logic [8:0] VPIX_PENT = 9'd80,
  parameter logic [8:0] VPIX_ATM  = 9'd76,
  parameter logic [8:0] VINT_LINE = 9'd319,
  parameter logic [6:0] INT_LEN   = 7'd64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cend_i,
  input  logic       hsync_start_i,
  input  logic       line_start_i,
  input  logic       hint_start_i,
  input  logic       mode_atm_n_pent_i,
`ifdef SYNCV_INT_ACK_EN
  input  logic       int_ack_i,
`endif
  output logic [8:0] vcount_o,
  output logic       vblank_o,
  output logic       vsync_o,
  output logic       vpix_o,
  output logic       frame_start_o,
  output logic       int_req_o
);

  localparam logic [8:0] VPIX_PENT_LEN = 9'd192;
  localparam logic [8:0] VPIX_ATM_LEN  = 9'd200;

  logic [8:0] vcount_q, vcount_d;
  logic       vblank_q, vblank_d;
  logic       vsync_q, vsync_d;
  logic       vpix_q, vpix_d;
  logic       frame_start_q, frame_start_d;
  logic [6:0] int_cnt_q, int_cnt_d;
  logic       int_req_q, int_req_d;
  logic       int_trig;
  logic       int_ack_hit;

  // Wrap-around subtract turns a two-sided range test into one unsigned compare.
  function automatic logic in_window(input logic [8:0] v, input logic [8:0] beg,
                                     input logic [8:0] len);
    logic [8:0] off;
    off = v - beg;
    return (off < len);
  endfunction

  assign int_trig = hint_start_i && (vcount_q == VINT_LINE);
`ifdef SYNCV_INT_ACK_EN
  assign int_ack_hit = int_ack_i && int_req_q;
`else
  assign int_ack_hit = 1'b0;
`endif

  // Next-state for line counter, vertical decodes, pixel window and INT counter
  always_comb begin
    vcount_d      = vcount_q;
    vblank_d      = vblank_q;
    vsync_d       = vsync_q;
    vpix_d        = vpix_q;
    frame_start_d = 1'b0;
    int_cnt_d     = int_cnt_q;

    if (hsync_start_i) begin
      if (vcount_q == (VPERIOD - 9'd1)) begin
        vcount_d      = 9'd0;
        frame_start_d = 1'b1;
      end else begin
        vcount_d      = vcount_q + 9'd1;
      end
      vblank_d = in_window(vcount_d, VBLNK_BEG, VBLNK_END - VBLNK_BEG);
      vsync_d  = in_window(vcount_d, VSYNC_BEG, VSYNC_END - VSYNC_BEG);
    end else begin
      vcount_d = vcount_q;
    end

    // Range check on every line_start, so a mode switch never leaves the window stuck.
    if (line_start_i) begin
      if (mode_atm_n_pent_i) begin
        vpix_d = in_window(vcount_q, VPIX_ATM, VPIX_ATM_LEN);
      end else begin
        vpix_d = in_window(vcount_q, VPIX_PENT, VPIX_PENT_LEN);
      end
    end else begin
      vpix_d = vpix_q;
    end

    if (int_trig) begin
      int_cnt_d = INT_LEN;
    end else if (int_ack_hit) begin
      int_cnt_d = 7'd0;
    end else if (cend_i && (int_cnt_q != 7'd0)) begin
      int_cnt_d = int_cnt_q - 7'd1;
    end else begin
      int_cnt_d = int_cnt_q;
    end

    int_req_d = (int_cnt_d != 7'd0);
  end

  // State registers; reset overrides every strobe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vcount_q      <= 9'd0;
      vblank_q      <= 1'b0;
      vsync_q       <= 1'b0;
      vpix_q        <= 1'b0;
      frame_start_q <= 1'b0;
      int_cnt_q     <= 7'd0;
      int_req_q     <= 1'b0;
    end else begin
      vcount_q      <= vcount_d;
      vblank_q      <= vblank_d;
      vsync_q       <= vsync_d;
      vpix_q        <= vpix_d;
      frame_start_q <= frame_start_d;
      int_cnt_q     <= int_cnt_d;
      int_req_q     <= int_req_d;
    end
  end

  assign vcount_o      = vcount_q;
  assign vblank_o      = vblank_q;
  assign vsync_o       = vsync_q;
  assign vpix_o        = vpix_q;
  assign frame_start_o = frame_start_q;
  assign int_req_o     = int_req_q;

endmodule

// File: tb/tb_video_sync_v.sv
// Directed, table-driven bench for video_sync_v; int_ack checks compile in with SYNCV_INT_ACK_EN.
module tb_video_sync_v;

  logic       clk = 1'b0;
  logic       rst, cend, hs, ls, h_int, mode;
`ifdef SYNCV_INT_ACK_EN
  logic       int_ack;
`endif
  logic [8:0] vcount;
  logic       vblank, vsync, vpix, frame_start, int_req;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  video_sync_v dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .cend_i            (cend),
    .hsync_start_i     (hs),
    .line_start_i      (ls),
    .hint_start_i      (h_int),
    .mode_atm_n_pent_i (mode),
`ifdef SYNCV_INT_ACK_EN
    .int_ack_i         (int_ack),
`endif
    .vcount_o          (vcount),
    .vblank_o          (vblank),
    .vsync_o           (vsync),
    .vpix_o            (vpix),
    .frame_start_o     (frame_start),
    .int_req_o         (int_req)
  );

  typedef struct {
    logic       rst, cend, hs, ls, hint, mode;
    int         n;
    logic [8:0] vc;
    logic       vb, vs, vp, fs, irq;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Hold the given inputs for n clocks, then release all strobes; sample #1 after the edge.
  task automatic drive(input logic r, input logic c, input logic h, input logic l,
                       input logic hi, input logic m, input int n);
    for (int i = 0; i < n; i++) begin
      rst = r; cend = c; hs = h; ls = l; h_int = hi; mode = m;
      @(posedge clk);
      #1;
    end
    rst = 1'b0; cend = 1'b0; hs = 1'b0; ls = 1'b0; h_int = 1'b0;
  endtask

  task automatic add(input logic r, input logic c, input logic h, input logic l,
                     input logic hi, input logic m, input int n, input logic [8:0] vc,
                     input logic vb, input logic vs, input logic vp, input logic fs,
                     input logic irq);
    vec_t v;
    v.rst = r; v.cend = c; v.hs = h; v.ls = l; v.hint = hi; v.mode = m; v.n = n;
    v.vc = vc; v.vb = vb; v.vs = vs; v.vp = vp; v.fs = fs; v.irq = irq;
    tbl.push_back(v);
  endtask

  int vs_n, vs_min, vs_max, vb_n, fs_n, fs_line, vp_n, vp_bad, vc_bad, line, k;
  logic md, exp_vp, low_seen;

  initial begin
    rst = 1'b0; cend = 1'b0; hs = 1'b0; ls = 1'b0; h_int = 1'b0; mode = 1'b0;
`ifdef SYNCV_INT_ACK_EN
    int_ack = 1'b0;
`endif
    @(posedge clk);
    #1;

    //   rst cend hs ls hint mode  n     vc    vb vs vp fs int
    add(1, 0, 0, 0, 0, 0,   1, 9'd0,   0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   2, 9'd0,   0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,   1, 9'd1,   1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,   6, 9'd7,   1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,   1, 9'd8,   1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,   3, 9'd11,  1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,   1, 9'd12,  1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,  19, 9'd31,  1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,   1, 9'd32,  0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,   1, 9'd32,  0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,  48, 9'd80,  0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,   1, 9'd80,  0, 0, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0,   1, 9'd81,  0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 191, 9'd272, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0,   1, 9'd272, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1,   1, 9'd272, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0,   3, 9'd275, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 1,   1, 9'd275, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0,   1, 9'd276, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 1,   1, 9'd276, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0,   1, 9'd276, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,  42, 9'd318, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0,   1, 9'd318, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,   1, 9'd319, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0,   1, 9'd319, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0,  63, 9'd319, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0,   1, 9'd319, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,   1, 9'd0,   1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0,   1, 9'd0,   1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 319, 9'd319, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0,   1, 9'd319, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 151, 9'd150, 0, 0, 0, 0, 1);
    add(1, 1, 1, 1, 1, 1,   1, 9'd0,   0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,   3, 9'd0,   0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].cend, tbl[i].hs, tbl[i].ls, tbl[i].hint, tbl[i].mode, tbl[i].n);
      chk($sformatf("v%0d.vcount", i), 16'(vcount), 16'(tbl[i].vc));
      chk($sformatf("v%0d.vblank", i), 16'(vblank), 16'(tbl[i].vb));
      chk($sformatf("v%0d.vsync", i), 16'(vsync), 16'(tbl[i].vs));
      chk($sformatf("v%0d.vpix", i), 16'(vpix), 16'(tbl[i].vp));
      chk($sformatf("v%0d.frame_start", i), 16'(frame_start), 16'(tbl[i].fs));
      chk($sformatf("v%0d.int_req", i), 16'(int_req), 16'(tbl[i].irq));
    end

    // Full frame walk: Pentagon window, switch to ATM at line 100.
    drive(1, 0, 0, 0, 0, 0, 1);
    vs_n = 0; vs_min = 999; vs_max = -1; vb_n = 0; fs_n = 0; fs_line = -1;
    vp_n = 0; vp_bad = 0; vc_bad = 0; md = 1'b0;
    for (int l = 1; l <= 320; l++) begin
      line = l % 320;
      drive(0, 0, 1, 0, 0, md, 1);
      if (vcount !== 9'(line)) vc_bad++;
      if (vsync === 1'b1) begin
        vs_n++;
        if (line < vs_min) vs_min = line;
        if (line > vs_max) vs_max = line;
      end
      if (vblank === 1'b1) vb_n++;
      if (frame_start === 1'b1) begin fs_n++; fs_line = line; end
      if (l == 100) md = 1'b1;
      drive(0, 0, 0, 1, 0, md, 1);
      if (frame_start === 1'b1) fs_n++;
      exp_vp = md ? (line >= 76 && line < 276) : (line >= 80 && line < 272);
      if (vpix !== exp_vp) vp_bad++;
      if (vpix === 1'b1) vp_n++;
    end
    chk("frame.vcount_seq", 16'(vc_bad), 16'd0);
    chk("frame.vsync_lines", 16'(vs_n), 16'd4);
    chk("frame.vsync_first", 16'(vs_min), 16'd8);
    chk("frame.vsync_last", 16'(vs_max), 16'd11);
    chk("frame.vblank_lines", 16'(vb_n), 16'd32);
    chk("frame.fs_count", 16'(fs_n), 16'd1);
    chk("frame.fs_line", 16'(fs_line), 16'd0);
    chk("frame.vpix_bad", 16'(vp_bad), 16'd0);
    chk("frame.vpix_lines", 16'(vp_n), 16'd196);

    // Retrigger at counter 10 coinciding with cend: 64 more cends, no gap.
    drive(1, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 0, 0, 319);
    drive(0, 0, 0, 0, 1, 0, 1);
    chk("retrig.start", 16'(int_req), 16'd1);
    low_seen = 1'b0;
    for (int i = 0; i < 54; i++) begin
      drive(0, 1, 0, 0, 0, 0, 1);
      if (int_req !== 1'b1) low_seen = 1'b1;
    end
    drive(0, 1, 0, 0, 1, 0, 1);
    if (int_req !== 1'b1) low_seen = 1'b1;
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      drive(0, 1, 0, 0, 0, 0, 1);
      if (int_req !== 1'b1) begin k = i; break; end
    end
    chk("retrig.no_gap", 16'(low_seen), 16'd0);
    chk("retrig.len", 16'(k), 16'd64);

`ifdef SYNCV_INT_ACK_EN
    drive(1, 0, 0, 0, 0, 0, 1);
    int_ack = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1);
    int_ack = 1'b0;
    chk("ack.idle_int", 16'(int_req), 16'd0);
    chk("ack.idle_vcount", 16'(vcount), 16'd0);
    drive(0, 0, 1, 0, 0, 0, 319);
    drive(0, 0, 0, 0, 1, 0, 1);
    drive(0, 1, 0, 0, 0, 0, 19);
    chk("ack.before", 16'(int_req), 16'd1);
    int_ack = 1'b1;
    drive(0, 1, 0, 0, 0, 0, 1);
    int_ack = 1'b0;
    chk("ack.release", 16'(int_req), 16'd0);
    drive(0, 1, 0, 0, 0, 0, 3);
    chk("ack.stays_low", 16'(int_req), 16'd0);
    int_ack = 1'b1;
    drive(0, 0, 0, 0, 1, 0, 1);
    int_ack = 1'b0;
    chk("ack.trig_wins", 16'(int_req), 16'd1);
    drive(0, 1, 0, 0, 0, 0, 63);
    chk("ack.len63", 16'(int_req), 16'd1);
    drive(0, 1, 0, 0, 0, 0, 1);
    chk("ack.len64", 16'(int_req), 16'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
